mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters; index 0 = A reader, 1 = B reader, 2 = C writer.
REQ-002 Parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum GRANT cycles before error; range 1..65535.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  NUM_REQ  per-requester transfer request (do_tran style), level.
REQ-007 addr_i  input  NUM_REQ x ADDR_WIDTH  per-requester byte address.
REQ-008 wr_i  input  NUM_REQ  per-requester direction; 1 = write, 0 = read.
REQ-009 done_o  output  NUM_REQ  one-cycle completion pulse to the granted requester (tran_done style).
REQ-010 grant_o  output  NUM_REQ  one-hot current owner; all zero when no owner.
REQ-011 mem_valid_o  output  1  transfer request to memory controller.
REQ-012 mem_addr_o  output  ADDR_WIDTH  address of the granted requester.
REQ-013 mem_we_o  output  1  direction of the granted requester.
REQ-014 mem_ready_i  input  1  one-cycle pulse; memory has completed the transfer.
REQ-015 timeout_o  output  1  sticky error; set on GRANT timeout.

Function
REQ-016 FSM states: IDLE, GRANT, RELEASE.
- IDLE->GRANT when any req_i is 1.
- GRANT->RELEASE on mem_ready_i or timeout.
- RELEASE->IDLE always.
REQ-017 Winner selection in IDLE is round-robin.
- Search starts at pointer ptr and proceeds ptr, ptr+1, ... modulo NUM_REQ.
- The first asserted req_i wins.
- Winner index is registered on IDLE->GRANT.
REQ-018 ptr reset value is 0; ptr becomes (winner+1) mod NUM_REQ on GRANT->RELEASE; ptr is otherwise unchanged.
REQ-019 Latency: req_i sampled high in IDLE at cycle N gives mem_valid_o=1 and grant_o set at cycle N+1.
REQ-020 In GRANT: mem_valid_o=1; mem_addr_o and mem_we_o come combinationally from the registered winner's addr_i and wr_i.
REQ-021 In IDLE and RELEASE: mem_valid_o=0, grant_o=0, mem_addr_o=0, mem_we_o=0.
REQ-022 done_o[winner] is 1 for exactly one cycle, in the cycle mem_ready_i=1 during GRANT; done_o is otherwise 0.
REQ-023 The RELEASE cycle blocks re-granting a request that is deasserted one cycle after done_o.
REQ-024 A requester dropping req_i mid-GRANT does not abort the transfer; the arbiter still waits for mem_ready_i.
REQ-025 mem_ready_i in IDLE or RELEASE is ignored: no done_o, no state change.
REQ-026 A 16-bit watchdog counter clears on entering GRANT and increments each GRANT cycle.
- When the count reaches TIMEOUT_CYCLES without mem_ready_i: go to RELEASE, set timeout_o, no done_o, ptr still advances.
REQ-027 If mem_ready_i and timeout occur in the same cycle, mem_ready_i wins: done_o pulses and timeout_o is not set.
REQ-028 timeout_o clears only on reset.
REQ-029 Simultaneous requests are serviced in round-robin order; no requester waits more than NUM_REQ-1 completed transfers.

Reset
REQ-030 While reset=1 at a clock edge: state=IDLE, ptr=0, watchdog=0, timeout_o=0, winner=0.
REQ-031 Reset values of outputs: done_o=0, grant_o=0, mem_valid_o=0, mem_addr_o=0, mem_we_o=0, timeout_o=0.
REQ-032 Reset asserted mid-GRANT abandons the transfer: no done_o, and mem_valid_o=0 in the following cycle.
REQ-033 The first grant after reset deassertion occurs no earlier than one cycle after the first IDLE cycle with a request.

Structure
REQ-034 Shared package mem_arb_pkg holds:
- the state enum arb_state_t (IDLE, GRANT, RELEASE);
- localparams REQ_A=0, REQ_B=1, REQ_C=2;
- default NUM_REQ.
REQ-035 One sub-module rr_priority_picker: combinational; inputs req vector and ptr; outputs winner index and any_req.
REQ-036 All other logic (FSM, ptr, watchdog, output mux) lives in mem_port_arbiter.

Verification
REQ-037 Reset, then req_i=3'b100 at cycle 5, mem_ready_i at cycle 8 -> mem_valid_o=1 cycles 6-8, done_o=3'b100 at cycle 8, RELEASE at cycle 9, ptr=0.
REQ-038 req_i=3'b111 held continuously, mem_ready_i 2 cycles after each grant -> grant order 0,1,2,0; each done_o one cycle wide.
REQ-039 Requester 1 drops req_i one cycle after done_o while requester 0 keeps requesting -> requester 1 is never granted twice for one request; next grant goes to 2 if requesting, else 0.
REQ-040 TIMEOUT_CYCLES=4, grant to 0, no mem_ready_i -> RELEASE after 4 GRANT cycles, timeout_o=1 sticky, no done_o, next grant goes to 1.
REQ-041 Reset pulsed in the 2nd GRANT cycle -> next cycle IDLE, all outputs 0; a later mem_ready_i pulse produces no done_o.
REQ-042 mem_ready_i pulsed in IDLE with no request -> no done_o, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Requester slots: 0 = A reader, 1 = B reader, 2 = C writer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;
    localparam int REQ_C = 2;

    localparam int DEFAULT_NUM_REQ = 3;
    localparam int WATCHDOG_WIDTH  = 16;

    // Index width that stays legal for a single-requester build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping modulo NUM_REQ) wins.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(int'(ptr) + i)]) begin
                winner  = wrap_idx(int'(ptr) + i);
                any_req = 1'b1;
            end
        end
    end

    function automatic logic [IDX_W-1:0] wrap_idx(input int pos);
        int p;
        p = pos;
        if (p >= NUM_REQ) begin
            p = p - NUM_REQ;
        end
        return IDX_W'(p);
    endfunction

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// with a per-grant watchdog that flags a sticky timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ-1:0]                  wr_i,
    output logic [NUM_REQ-1:0]                  done_o,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic                                mem_valid_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic                                mem_we_o,
    input  logic                                mem_ready_i,
    output logic                                timeout_o
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST = WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t                state;
    logic [IDX_W-1:0]          ptr;
    logic [IDX_W-1:0]          winner;
    logic [WATCHDOG_WIDTH-1:0] watchdog;
    logic [NUM_REQ-1:0]        grant_q;
    logic                      valid_q;
    logic                      timeout_q;

    logic [IDX_W-1:0] pick_winner;
    logic             pick_any;
    logic             ready_hit;
    logic             wd_expired;
    logic [IDX_W-1:0] next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req_i),
        .ptr     (ptr),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    // The watchdog holds the count of GRANT cycles already elapsed, so the
    // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign ready_hit  = (state == GRANT) && mem_ready_i;
    assign wd_expired = (state == GRANT) && (watchdog == WD_LAST);
    assign next_ptr   = (winner == LAST_IDX) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            watchdog  <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        winner   <= pick_winner;
                        watchdog <= '0;
                        grant_q  <= NUM_REQ'(1) << pick_winner;
                        valid_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    watchdog <= watchdog + 1'b1;
                    if (ready_hit || wd_expired) begin
                        state   <= RELEASE;
                        ptr     <= next_ptr;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                    end
                    // A completion in the final watchdog cycle is not an error.
                    if (wd_expired && !ready_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr_o = '0;
        mem_we_o   = 1'b0;
        done_o     = '0;
        if (valid_q) begin
            mem_addr_o = addr_i[winner];
            mem_we_o   = wr_i[winner];
        end
        if (ready_hit) begin
            done_o = grant_q;
        end
    end

    assign grant_o     = grant_q;
    assign mem_valid_o = valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table plus
// hand-written reset-during-grant sequence, checked through a scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int TO = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NR-1:0]           req_i;
    logic [NR-1:0][AW-1:0]   addr_i;
    logic [NR-1:0]           wr_i;
    logic [NR-1:0]           done_o;
    logic [NR-1:0]           grant_o;
    logic                    mem_valid_o;
    logic [AW-1:0]           mem_addr_o;
    logic                    mem_we_o;
    logic                    mem_ready_i;
    logic                    timeout_o;

    mem_port_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .wr_i        (wr_i),
        .done_o      (done_o),
        .grant_o     (grant_o),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_ready_i (mem_ready_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       rdy;
        logic [2:0] grant;
        logic [2:0] done;
        logic       to;
    } vec_t;

    typedef struct packed {
        logic [2:0]  grant;
        logic        valid;
        logic [15:0] addr;
        logic        we;
        logic [2:0]  done;
        logic        to;
    } obs_t;

    obs_t exp_q[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic rdy,
                                input logic [2:0] g, input logic [2:0] d, input logic to);
        vec_t v;
        v.rst = rst; v.req = req; v.rdy = rdy; v.grant = g; v.done = d; v.to = to;
        return v;
    endfunction

    // Bus contents implied by a given owner: A at 0x1000, B at 0x2000, C writes 0x3000.
    function automatic obs_t expect_of(input vec_t v);
        obs_t o;
        o.grant = v.grant;
        o.valid = |v.grant;
        o.done  = v.done;
        o.to    = v.to;
        case (v.grant)
            3'b001:  begin o.addr = 16'h1000; o.we = 1'b0; end
            3'b010:  begin o.addr = 16'h2000; o.we = 1'b0; end
            3'b100:  begin o.addr = 16'h3000; o.we = 1'b1; end
            default: begin o.addr = 16'h0000; o.we = 1'b0; end
        endcase
        return o;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        reset       = v.rst;
        req_i       = v.req;
        mem_ready_i = v.rdy;
        exp_q.push_back(expect_of(v));
    endtask

    task automatic check_output(input string name);
        obs_t act;
        obs_t ex;
        checks++;
        act = {grant_o, mem_valid_o, mem_addr_o, mem_we_o, done_o, timeout_o};
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got grant=%b", name, grant_o);
        end else begin
            ex = exp_q.pop_front();
            if (act !== ex) begin
                errors++;
                $display("[TB] FAIL %s: got grant=%b valid=%b addr=%h we=%b done=%b to=%b, want grant=%b valid=%b addr=%h we=%b done=%b to=%b",
                         name, act.grant, act.valid, act.addr, act.we, act.done, act.to,
                         ex.grant, ex.valid, ex.addr, ex.we, ex.done, ex.to);
            end
        end
    endtask

    // One cycle: drive just after the edge, compare mid-cycle, step to the next edge.
    task automatic run_row(input vec_t v, input string name);
        apply_stimulus(v);
        @(negedge clk);
        check_output(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        reset       = 1'b1;
        req_i       = '0;
        mem_ready_i = 1'b0;
        addr_i[REQ_A] = 16'h1000;
        addr_i[REQ_B] = 16'h2000;
        addr_i[REQ_C] = 16'h3000;
        wr_i        = 3'b100;

        // Single C write completing after three GRANT cycles, then ready in IDLE.
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b100, 0, 3'b100, 3'b000, 0));
        tbl.push_back(mk(0, 3'b100, 0, 3'b100, 3'b000, 0));
        tbl.push_back(mk(0, 3'b100, 1, 3'b100, 3'b100, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        // All three requesting: round-robin order 0,1,2,0.
        for (int k = 0; k < 4; k++) begin
            logic [2:0] g;
            g = 3'b001 << (k % 3);
            tbl.push_back(mk(0, 3'b111, 0, 3'b000, 3'b000, 0));
            tbl.push_back(mk(0, 3'b111, 0, g,      3'b000, 0));
            tbl.push_back(mk(0, 3'b111, 0, g,      3'b000, 0));
            tbl.push_back(mk(0, 3'b111, 1, g,      g,      0));
            tbl.push_back(mk(0, (k == 3) ? 3'b000 : 3'b111, 0, 3'b000, 3'b000, 0));
        end
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        // B drops its request in the RELEASE cycle; A is served next.
        tbl.push_back(mk(0, 3'b011, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b011, 0, 3'b010, 3'b000, 0));
        tbl.push_back(mk(0, 3'b011, 1, 3'b010, 3'b010, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 3'b001, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        // C drops its request mid-GRANT; transfer still waits for ready.
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b100, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 1, 3'b100, 3'b100, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        // Ready lands in the last watchdog cycle: completion wins, no timeout.
        tbl.push_back(mk(0, 3'b001, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 3'b001, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0));
        // No ready for four GRANT cycles: timeout, sticky flag, ptr advances to B.
        tbl.push_back(mk(0, 3'b001, 0, 3'b000, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 3'b000, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(0, 3'b011, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(0, 3'b011, 0, 3'b010, 3'b000, 1));
        tbl.push_back(mk(0, 3'b011, 1, 3'b010, 3'b010, 1));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 1));

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] running %0d table vectors", tbl.size());
        foreach (tbl[i]) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

        // Reset clears the sticky timeout and the round-robin pointer.
        reset       = 1'b1;
        req_i       = '0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_row(mk(0, 3'b001, 0, 3'b000, 3'b000, 0), "rst_clears_timeout");

        cyc = 0;
        while (mem_valid_o !== 1'b1 && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 0 || grant_o !== 3'b001) begin
            errors++;
            $display("[TB] FAIL grant_latency: got %0d extra cycles grant=%b, want 0 extra grant=001", cyc, grant_o);
        end

        // Reset in the second GRANT cycle abandons the transfer.
        run_row(mk(0, 3'b001, 0, 3'b001, 3'b000, 0), "grant_cycle1");
        run_row(mk(1, 3'b001, 0, 3'b001, 3'b000, 0), "reset_in_grant");
        run_row(mk(0, 3'b000, 1, 3'b000, 3'b000, 0), "after_reset_idle");
        run_row(mk(0, 3'b000, 1, 3'b000, 3'b000, 0), "late_ready_ignored");
        run_row(mk(0, 3'b111, 0, 3'b000, 3'b000, 0), "ptr_reset_idle");
        run_row(mk(0, 3'b111, 0, 3'b001, 3'b000, 0), "ptr_reset_grant");
        run_row(mk(0, 3'b111, 1, 3'b001, 3'b001, 0), "ptr_reset_done");
        run_row(mk(0, 3'b000, 0, 3'b000, 3'b000, 0), "final_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
